// File: rtl/miner_scheduler.sv
// miner_scheduler: feeds NUM_CORES hash cores interleaved nonce lanes from one cursor and gathers their golden-nonce hits.
// Latency: first issue the cycle after start; core_hit at t gives hit_valid at t+2 when the result FIFO has room.
// Backpressure: hit_ready low fills the FIFO, then hits park in per-core pending slots; a hit onto an occupied slot is dropped and counted.
//
// Ports: hash_clk / reset (synchronous, active-high) | start, base_nonce: begin a scan at an aligned base
//        core_valid, core_nonce: issue strobe and per-lane nonces (lane i = cursor + i)
//        core_hit, core_hit_nonce: per-core hit strobes and their nonces
//        hit_valid, hit_ready, hit_nonce, hit_core: result FIFO head
//        busy, done, exhausted, hit_count, drop_count: status and saturating counters
// Optional: MINER_SCHED_DISPLAY_EN adds a simulation-only printer of popped hits that ends the run once done rises.

module miner_sched_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         full,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign pop    = rd_vld && rd_rdy;
    // A pop frees the slot the push needs, so a full FIFO still accepts a write in a pop cycle.
    assign push   = wr_vld && (!full || pop);
    assign full   = (count == (AW+1)'(DEPTH));
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

module miner_scheduler #(
    parameter int NUM_CORES  = 4,
    parameter int NONCE_W    = 32,
    parameter int LOOP_LOG2  = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int MAX_HITS   = 1
) (
    input  logic                         hash_clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [NONCE_W-1:0]           base_nonce,
    output logic                         core_valid,
    output logic [NUM_CORES*NONCE_W-1:0] core_nonce,
    input  logic [NUM_CORES-1:0]         core_hit,
    input  logic [NUM_CORES*NONCE_W-1:0] core_hit_nonce,
    output logic                         hit_valid,
    input  logic                         hit_ready,
    output logic [NONCE_W-1:0]           hit_nonce,
    output logic [3:0]                   hit_core,
    output logic                         busy,
    output logic                         done,
    output logic                         exhausted,
    output logic [15:0]                  hit_count,
    output logic [15:0]                  drop_count
);
    localparam int                 DIV_W      = (LOOP_LOG2 > 0) ? LOOP_LOG2 : 1;
    localparam logic [NONCE_W-1:0] ALIGN_MASK = ~(NONCE_W'(NUM_CORES - 1));
    localparam logic [NONCE_W:0]   STRIDE     = (NONCE_W+1)'(NUM_CORES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t               state;
    state_t               state_nxt;
    logic [NONCE_W-1:0]   cursor;
    logic [NONCE_W:0]     cursor_sum;
    logic [DIV_W-1:0]     div;
    logic [DIV_W-1:0]     div_nxt;
    logic                 start_scan;
    logic                 capture_en;
    logic                 issue_wrap;
    logic                 max_reached;
    logic [NUM_CORES-1:0] pending;
    logic [NUM_CORES-1:0] pending_nxt;
    logic [NUM_CORES-1:0] cap;
    logic [NUM_CORES-1:0] drop;
    logic [NUM_CORES-1:0] drain_sel;
    logic [NONCE_W-1:0]   pend_nonce [NUM_CORES];
    logic                 sel_any;
    logic [3:0]           sel_idx;
    logic [NONCE_W-1:0]   sel_nonce;
    logic                 fifo_full;
    logic                 push_ok;
    logic [4:0]           cap_n;
    logic [4:0]           drop_n;
    logic [15:0]          hit_count_nxt;
    logic [15:0]          drop_count_nxt;
    logic [NONCE_W+3:0]   fifo_head;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [4:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {12'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    assign busy       = (state == RUN) || (state == DRAIN);
    assign done       = (state == DONE);
    assign start_scan = start && ((state == IDLE) || (state == DONE));
    assign capture_en = busy;
    assign core_valid = (state == RUN) && (div == '0);
    assign cursor_sum = {1'b0, cursor} + STRIDE;
    // Carry out of the cursor means the group just issued was the last one in the nonce space.
    assign issue_wrap = core_valid && cursor_sum[NONCE_W];
    // The divider's natural wrap gives the 2^LOOP_LOG2 issue period.
    assign div_nxt    = (LOOP_LOG2 == 0) ? '0 : div + 1'b1;

    // Lanes read 0 between issues so the bus is quiet outside issue strobes and after reset.
    always_comb begin
        core_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            core_nonce[i*NONCE_W +: NONCE_W] = core_valid ? cursor + NONCE_W'(i) : '0;
        end
    end

    // Lowest-index pending slot wins the FIFO write port.
    always_comb begin
        sel_any   = 1'b0;
        sel_idx   = '0;
        sel_nonce = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pending[i] && !sel_any) begin
                sel_any   = 1'b1;
                sel_idx   = 4'(i);
                sel_nonce = pend_nonce[i];
            end
        end
    end

    assign push_ok = sel_any && (!fifo_full || (hit_valid && hit_ready));

    // A slot that drains this cycle can take a new hit at the same time; only a
    // hit onto a slot that stays occupied is lost.
    always_comb begin
        drain_sel = '0;
        cap       = '0;
        drop      = '0;
        cap_n     = '0;
        drop_n    = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            drain_sel[i] = push_ok && (sel_idx == 4'(i));
            cap[i]       = capture_en && core_hit[i] && (!pending[i] || drain_sel[i]);
            drop[i]      = capture_en && core_hit[i] && pending[i] && !drain_sel[i];
            cap_n        = cap_n + 5'(cap[i]);
            drop_n       = drop_n + 5'(drop[i]);
        end
        pending_nxt = (pending & ~drain_sel) | cap;
    end

    assign hit_count_nxt  = sat_add(hit_count, cap_n);
    assign drop_count_nxt = sat_add(drop_count, drop_n);
    // Compare against the post-capture count so issuing stops the cycle right after the last wanted hit.
    assign max_reached    = (MAX_HITS != 0) && (hit_count_nxt >= 16'(MAX_HITS));

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue_wrap || max_reached) state_nxt = DRAIN;
            DRAIN:   if (pending_nxt == '0) state_nxt = DONE;
            DONE:    if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            cursor     <= '0;
            div        <= '0;
            exhausted  <= 1'b0;
            hit_count  <= '0;
            drop_count <= '0;
            pending    <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_nonce[i] <= '0;
            end
        end else begin
            if (start_scan) begin
                cursor     <= base_nonce & ALIGN_MASK;
                div        <= '0;
                exhausted  <= 1'b0;
                hit_count  <= '0;
                drop_count <= '0;
            end else begin
                if (core_valid) begin
                    cursor <= cursor_sum[NONCE_W-1:0];
                end
                if (issue_wrap) begin
                    exhausted <= 1'b1;
                end
                if (state == RUN) begin
                    div <= div_nxt;
                end
                hit_count  <= hit_count_nxt;
                drop_count <= drop_count_nxt;
            end
            pending <= pending_nxt;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (cap[i]) begin
                    pend_nonce[i] <= core_hit_nonce[i*NONCE_W +: NONCE_W];
                end
            end
        end
    end

    miner_sched_fifo #(
        .W     (NONCE_W + 4),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (hash_clk),
        .reset  (reset),
        .wr_vld (push_ok),
        .wr_dat ({sel_idx, sel_nonce}),
        .full   (fifo_full),
        .rd_vld (hit_valid),
        .rd_rdy (hit_ready),
        .rd_dat (fifo_head)
    );

    assign hit_core  = fifo_head[NONCE_W+3:NONCE_W];
    assign hit_nonce = fifo_head[NONCE_W-1:0];

`ifdef MINER_SCHED_DISPLAY_EN
    always @(posedge hash_clk) begin
        if (!reset && hit_valid && hit_ready) begin
            $display("%h %h", hit_core, hit_nonce);
        end
        if (!reset && done) begin
            $finish(0);
        end
    end
`else
    // Synthesizable build: no simulation-only side effects.
`endif
endmodule

// File: tb/tb_miner_scheduler.sv
module tb_miner_scheduler;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    // Instance A: default parameters (LOOP_LOG2=0, MAX_HITS=1)
    logic         a_start, a_rdy, a_core_valid, a_hit_valid, a_busy, a_done, a_exhausted;
    logic [31:0]  a_base, a_hit_nonce;
    logic [3:0]   a_hit, a_hit_core;
    logic [127:0] a_hnon, a_core_nonce;
    logic [15:0]  a_hit_count, a_drop_count;

    // Instance B: LOOP_LOG2=2, MAX_HITS=0
    logic         b_start, b_rdy, b_core_valid, b_hit_valid, b_busy, b_done, b_exhausted;
    logic [31:0]  b_base, b_hit_nonce;
    logic [3:0]   b_hit, b_hit_core;
    logic [127:0] b_hnon, b_core_nonce;
    logic [15:0]  b_hit_count, b_drop_count;

    miner_scheduler u_a (
        .hash_clk(clk), .reset(rst), .start(a_start), .base_nonce(a_base),
        .core_valid(a_core_valid), .core_nonce(a_core_nonce), .core_hit(a_hit),
        .core_hit_nonce(a_hnon), .hit_valid(a_hit_valid), .hit_ready(a_rdy),
        .hit_nonce(a_hit_nonce), .hit_core(a_hit_core), .busy(a_busy), .done(a_done),
        .exhausted(a_exhausted), .hit_count(a_hit_count), .drop_count(a_drop_count)
    );

    miner_scheduler #(.LOOP_LOG2(2), .MAX_HITS(0)) u_b (
        .hash_clk(clk), .reset(rst), .start(b_start), .base_nonce(b_base),
        .core_valid(b_core_valid), .core_nonce(b_core_nonce), .core_hit(b_hit),
        .core_hit_nonce(b_hnon), .hit_valid(b_hit_valid), .hit_ready(b_rdy),
        .hit_nonce(b_hit_nonce), .hit_core(b_hit_core), .busy(b_busy), .done(b_done),
        .exhausted(b_exhausted), .hit_count(b_hit_count), .drop_count(b_drop_count)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic         st;
        logic [31:0]  base;
        logic [3:0]   hit;
        logic [127:0] hn;
        logic         rdy;
        logic [127:0] exp;
    } vec_t;

    // exp = {valid, lane0, lane3, busy, done, exhausted, hit_valid, hit_core, hit_nonce, hit_count}
    function automatic vec_t mk(input logic st, input logic [31:0] base, input logic [3:0] hit,
                                input logic [127:0] hn, input logic rdy, input logic cv,
                                input logic [31:0] l0, input logic [31:0] l3, input logic bz,
                                input logic dn, input logic ex, input logic hv,
                                input logic [3:0] hc, input logic [31:0] hnn, input logic [15:0] cnt);
        vec_t v;
        v.st   = st;
        v.base = base;
        v.hit  = hit;
        v.hn   = hn;
        v.rdy  = rdy;
        v.exp  = {7'b0, cv, l0, l3, bz, dn, ex, hv, hc, hnn, cnt};
        return v;
    endfunction

    function automatic logic [127:0] obs_a();
        return {7'b0, a_core_valid, a_core_nonce[31:0], a_core_nonce[127:96], a_busy, a_done,
                a_exhausted, a_hit_valid, a_hit_core, a_hit_nonce, a_hit_count};
    endfunction

    function automatic logic [127:0] head_b();
        return {91'b0, b_hit_valid, b_hit_core, b_hit_nonce};
    endfunction

    vec_t va [21];

    initial begin
        logic        iss;
        logic [31:0] e0;
        logic [31:0] e3;

        // Reset, scan from 0x100, hit on core 2 stops at MAX_HITS=1, hits ignored in DONE,
        // wrap from 0xFFFFFFF8, unaligned base, two simultaneous hits drained lowest core first.
        va[0]  = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, N, N, N, 4'h0, 32'h0,   16'd0);
        va[1]  = mk(Y, 32'h100,      4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, N, N, N, 4'h0, 32'h0,   16'd0);
        va[2]  = mk(N, 32'h0,        4'h0, 128'h0,                          N, Y, 32'h100,      32'h103,      Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[3]  = mk(N, 32'h0,        4'h0, 128'h0,                          N, Y, 32'h104,      32'h107,      Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[4]  = mk(N, 32'h0,        4'h4, {32'h0, 32'h55, 64'h0},          N, Y, 32'h108,      32'h10B,      Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[5]  = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        Y, N, N, N, 4'h0, 32'h0,   16'd1);
        va[6]  = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, Y, N, Y, 4'h2, 32'h55,  16'd1);
        va[7]  = mk(N, 32'h0,        4'h1, {96'h0, 32'h77},                 Y, N, 32'h0,        32'h0,        N, Y, N, Y, 4'h2, 32'h55,  16'd1);
        va[8]  = mk(Y, 32'hFFFFFFF8, 4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, Y, N, N, 4'h0, 32'h0,   16'd1);
        va[9]  = mk(N, 32'h0,        4'h0, 128'h0,                          N, Y, 32'hFFFFFFF8, 32'hFFFFFFFB, Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[10] = mk(N, 32'h0,        4'h0, 128'h0,                          N, Y, 32'hFFFFFFFC, 32'hFFFFFFFF, Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[11] = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        Y, N, Y, N, 4'h0, 32'h0,   16'd0);
        va[12] = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, Y, Y, N, 4'h0, 32'h0,   16'd0);
        va[13] = mk(Y, 32'h203,      4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, Y, Y, N, 4'h0, 32'h0,   16'd0);
        va[14] = mk(N, 32'h0,        4'h0, 128'h0,                          N, Y, 32'h200,      32'h203,      Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[15] = mk(N, 32'h0,        4'h9, {32'h204, 64'h0, 32'h201},       N, Y, 32'h204,      32'h207,      Y, N, N, N, 4'h0, 32'h0,   16'd0);
        va[16] = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        Y, N, N, N, 4'h0, 32'h0,   16'd2);
        va[17] = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        Y, N, N, Y, 4'h0, 32'h201, 16'd2);
        va[18] = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, Y, N, Y, 4'h0, 32'h201, 16'd2);
        va[19] = mk(N, 32'h0,        4'h0, 128'h0,                          Y, N, 32'h0,        32'h0,        N, Y, N, Y, 4'h0, 32'h201, 16'd2);
        va[20] = mk(N, 32'h0,        4'h0, 128'h0,                          N, N, 32'h0,        32'h0,        N, Y, N, Y, 4'h3, 32'h204, 16'd2);

        rst = 1'b1;
        a_start = 1'b0; a_base = '0; a_hit = '0; a_hnon = '0; a_rdy = 1'b0;
        b_start = 1'b0; b_base = '0; b_hit = '0; b_hnon = '0; b_rdy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            a_start = va[i].st;
            a_base  = va[i].base;
            a_hit   = va[i].hit;
            a_hnon  = va[i].hn;
            a_rdy   = va[i].rdy;
            chk($sformatf("vecA[%0d]", i), obs_a(), va[i].exp);
            @(negedge clk);
        end
        a_start = 1'b0; a_hit = '0; a_hnon = '0; a_rdy = 1'b0;

        // Issue cadence with LOOP_LOG2=2: one group every 4 cycles, cursor steps by 4.
        b_start = 1'b1; b_base = 32'h0;
        @(negedge clk);
        b_start = 1'b0;
        for (int k = 0; k < 9; k++) begin
            iss = ((k % 4) == 0);
            e0  = iss ? 32'(k) : 32'h0;
            e3  = iss ? 32'(k + 3) : 32'h0;
            chk($sformatf("cadence[%0d]", k), {63'b0, b_core_valid, b_core_nonce[31:0], b_core_nonce[127:96]},
                {63'b0, iss, e0, e3});
            @(negedge clk);
        end

        // Two cores hit together: core 1 leaves the FIFO before core 3.
        b_hit = 4'b1010; b_hnon = {32'hB, 32'h0, 32'hA, 32'h0}; b_rdy = 1'b1;
        @(negedge clk);
        b_hit = '0; b_hnon = '0;
        chk("pair count", {112'b0, b_hit_count}, 128'd2);
        chk("pair t+1 empty", {127'b0, b_hit_valid}, 128'd0);
        @(negedge clk);
        chk("pair head core1", head_b(), {91'b0, 1'b1, 4'd1, 32'hA});
        @(negedge clk);
        chk("pair head core3", head_b(), {91'b0, 1'b1, 4'd3, 32'hB});
        @(negedge clk);
        chk("pair drained busy", {126'b0, b_hit_valid, b_busy}, {126'b0, 1'b0, 1'b1});

        // Ten back-to-back hits on core 0 with no consumer: 8 in FIFO, 1 pending, 1 dropped.
        b_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            b_hit  = 4'b0001;
            b_hnon = {96'h0, 32'h1000 + 32'(k)};
            @(negedge clk);
        end
        b_hit = '0; b_hnon = '0;
        chk("flood counts", {96'b0, b_hit_count, b_drop_count}, {96'b0, 16'd11, 16'd1});
        b_rdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("flood pop[%0d]", k), head_b(), {91'b0, 1'b1, 4'd0, 32'h1000 + 32'(k)});
            @(negedge clk);
        end
        b_rdy = 1'b0;

        // Reset in the middle of a run clears everything by the next cycle.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("reset status", {55'b0, b_core_valid, b_busy, b_done, b_exhausted, b_hit_valid, b_hit_core,
                             b_hit_nonce, b_hit_count, b_drop_count}, 128'd0);
        chk("reset lanes", b_core_nonce, 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
